// File: rtl/barrel_rotr_pipe.sv
// Pipelined right rotator / logical right shifter with valid/ready handshakes.
// Stage k resolves amount bit k (shift by 2^k); one global stall freezes the whole pipe.
module barrel_rotr_pipe #(
   parameter int WIDTH = 8,
   parameter int LOG2W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [LOG2W-1:0] in_amt,
   input  logic             in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_mode
);

   // Index k is the input of stage k; index LOG2W is the output of the last stage.
   logic             pipe_valid [LOG2W+1];
   logic [WIDTH-1:0] pipe_data  [LOG2W+1];
   logic             pipe_mode  [LOG2W+1];
   // Remaining amount entering stage k, already shifted so its bit 0 is amount bit k.
   logic [LOG2W-1:0] pipe_amt   [LOG2W];

   logic stall;

   assign stall    = out_valid && !out_ready;
   assign in_ready = !stall;

   assign pipe_valid[0] = in_valid;
   assign pipe_data[0]  = in_data;
   assign pipe_mode[0]  = in_mode;
   assign pipe_amt[0]   = in_amt;

   generate
      for (genvar gi = 0; gi < LOG2W; gi++) begin : g_stage
         localparam int SH = 2 ** gi;

         logic             shift_en;
         logic [WIDTH-1:0] shr_data;
         logic [WIDTH-1:0] rot_data;
         logic [WIDTH-1:0] stage_result;
         logic             valid_reg;
         logic [WIDTH-1:0] data_reg;
         logic             mode_reg;

         if (gi < LOG2W - 1) begin : g_mid
            logic [LOG2W-1:0] amt_reg;

            assign shift_en = pipe_amt[gi][0];

            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  amt_reg <= '0;
               end else if (!stall) begin
                  amt_reg <= pipe_amt[gi] >> 1;
               end
            end

            assign pipe_amt[gi+1] = amt_reg;
         end else begin : g_last
            // Only one amount bit is left by now; the upper bits are always zero.
            assign shift_en = |pipe_amt[gi];
         end

         assign shr_data     = pipe_data[gi] >> SH;
         assign rot_data     = shr_data | (pipe_data[gi] << (WIDTH - SH));
         assign stage_result = !shift_en ? pipe_data[gi] :
                               (pipe_mode[gi] ? shr_data : rot_data);

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               valid_reg <= 1'b0;
               data_reg  <= '0;
               mode_reg  <= 1'b0;
            end else if (!stall) begin
               valid_reg <= pipe_valid[gi];
               data_reg  <= stage_result;
               mode_reg  <= pipe_mode[gi];
            end
         end

         assign pipe_valid[gi+1] = valid_reg;
         assign pipe_data[gi+1]  = data_reg;
         assign pipe_mode[gi+1]  = mode_reg;
      end
   endgenerate

   assign out_valid = pipe_valid[LOG2W];
   assign out_data  = pipe_data[LOG2W];
   assign out_mode  = pipe_mode[LOG2W];

endmodule
